// File: rtl/mmu_walk_port_arbiter_if.sv
// Walker-side request/response bus and cache walker port of the PTE read arbiter.
// slave: the arbiter's view. master: the environment (walkers + cache) view.
interface mmu_walk_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CHANNEL_NUM = 2
);

  // Walker channels
  logic [CHANNEL_NUM-1:0]            req_valid;
  logic [CHANNEL_NUM*ADDR_WIDTH-1:0] req_addr;
  logic [CHANNEL_NUM-1:0]            req_ready;
  logic [CHANNEL_NUM-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]             resp_data;
  logic                              flush;

  // Cache walker port
  logic [ADDR_WIDTH-1:0]             cache_address;
  logic                              cache_ren;
  logic [DATA_WIDTH-1:0]             cache_rdata;
  logic                              cache_miss;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  flush,
    input  cache_rdata,
    input  cache_miss,
    output req_ready,
    output resp_valid,
    output resp_data,
    output cache_address,
    output cache_ren
  );

  modport master (
    output req_valid,
    output req_addr,
    output flush,
    output cache_rdata,
    output cache_miss,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  cache_address,
    input  cache_ren
  );

endinterface

// File: rtl/mmu_walk_port_arbiter.sv
// Round-robin arbiter between page-table walkers and a single MMU-cache walker
// read port. Repeat PTE reads are served from a small fully-associative FIFO
// buffer; buffer misses are forwarded to the cache and held until it hits.
// Only one request is outstanding at a time.
module mmu_walk_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned PTE_ENTRIES = 4
) (
  input logic                    clk,
  input logic                    rst,
  mmu_walk_port_arbiter_if.slave bus
);

  // Byte-granule bits inside one PTE; ignored for tagging.
  localparam int unsigned G     = $clog2(DATA_WIDTH / 8);
  localparam int unsigned TAG_W = ADDR_WIDTH - G;
  localparam int unsigned CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int unsigned PTR_W = (PTE_ENTRIES > 1) ? $clog2(PTE_ENTRIES) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PTE_ENTRIES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCache,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Request context and response register
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CH_W-1:0]       ch_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_W-1:0]       rr_last_q;

  // PTE buffer
  logic [PTE_ENTRIES-1:0] ent_valid_q;
  logic [TAG_W-1:0]       ent_tag_q  [PTE_ENTRIES];
  logic [DATA_WIDTH-1:0]  ent_data_q [PTE_ENTRIES];
  logic [PTR_W-1:0]       fill_ptr_q;

  // Combinational helpers
  logic                  gnt_any;
  logic [CH_W-1:0]       gnt_idx;
  int unsigned           cand;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [TAG_W-1:0]      gnt_tag;
  logic                  buf_hit;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  lookup_hit;
  logic                  accept;
  logic                  fill;

  logic [CHANNEL_NUM-1:0] req_ready;
  logic [CHANNEL_NUM-1:0] resp_valid;
  logic [ADDR_WIDTH-1:0]  cache_address;
  logic                   cache_ren;

  // Round-robin pick: first valid channel after the last one served.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
      cand = (32'(rr_last_q) + k) % CHANNEL_NUM;
      if (!gnt_any && bus.req_valid[CH_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  assign gnt_addr = bus.req_addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_tag  = gnt_addr[ADDR_WIDTH-1:G];
  assign accept   = (state_q == StIdle) && gnt_any;
  assign fill     = (state_q == StCache) && !bus.cache_miss;

  // Buffer lookup; lowest matching index wins if tags are ever duplicated.
  always_comb begin
    buf_hit  = 1'b0;
    buf_data = '0;
    for (int unsigned e = 0; e < PTE_ENTRIES; e++) begin
      if (!buf_hit && ent_valid_q[e] && (ent_tag_q[e] == gnt_tag)) begin
        buf_hit  = 1'b1;
        buf_data = ent_data_q[e];
      end
    end
  end

  // A flush in the accept cycle must not return a stale translation.
  assign lookup_hit = buf_hit && !bus.flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = lookup_hit ? StResp : StCache;
        end
      end
      StCache: begin
        if (!bus.cache_miss) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    cache_ren     = 1'b0;
    cache_address = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
        end
      end
      StCache: begin
        cache_ren     = 1'b1;
        cache_address = addr_q;
      end
      StResp: begin
        resp_valid[ch_q] = 1'b1;
      end
      default: begin
        req_ready = '0;
      end
    endcase
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_data     = data_q;
  assign bus.cache_ren     = cache_ren;
  assign bus.cache_address = cache_address;

  // Request context, response data, arbitration history and fill pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      rr_last_q  <= CH_LAST;
      fill_ptr_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= gnt_addr;
        ch_q   <= gnt_idx;
        if (lookup_hit) begin
          data_q <= buf_data;
        end
      end
      if (fill) begin
        data_q     <= bus.cache_rdata;
        fill_ptr_q <= (fill_ptr_q == PTR_LAST) ? '0 : fill_ptr_q + 1'b1;
      end
      if (state_q == StResp) begin
        rr_last_q <= ch_q;
      end
    end
  end

  // Valid bits: flush beats a coincident fill, leaving that entry invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid_q <= '0;
    end else if (bus.flush) begin
      ent_valid_q <= '0;
    end else if (fill) begin
      ent_valid_q[fill_ptr_q] <= 1'b1;
    end
  end

  // Buffer payload; meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      ent_tag_q[fill_ptr_q]  <= addr_q[ADDR_WIDTH-1:G];
      ent_data_q[fill_ptr_q] <= bus.cache_rdata;
    end
  end

endmodule

// File: tb/tb_mmu_walk_port_arbiter.sv
// Directed bench for mmu_walk_port_arbiter with two channels and four buffer entries.
module tb_mmu_walk_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CN = 2;
  localparam int unsigned PE = 4;

  localparam logic [63:0] ADDR_X = 64'h0000_0000_8000_1008;
  localparam logic [63:0] ADDR_Y = 64'h0000_0000_8000_2000;
  localparam logic [63:0] DATA_X = 64'h0000_0000_2000_0C01;
  localparam logic [63:0] DATA_Y = 64'h0000_0000_3000_0001;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mmu_walk_port_arbiter_if #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CHANNEL_NUM (CN)
  ) bus ();

  mmu_walk_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CHANNEL_NUM (CN),
    .PTE_ENTRIES (PE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] oh(input int ch);
    logic [1:0] v;
    v = 2'b01 << ch;
    return 64'(v);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'h0);
    chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'h0);
    chk({tag, ".ren"}, 64'(bus.cache_ren), 64'h0);
  endtask

  // One request on channel ch. flush_at: 0 none, 1 in accept cycle, 2 in fill cycle.
  task automatic xact(input string tag, input int ch, input logic [63:0] addr,
                      input bit exp_hit, input int stalls, input logic [63:0] rdata,
                      input logic [63:0] exp_data, input int flush_at);
    bus.req_valid = '0;
    bus.req_valid[ch] = 1'b1;
    bus.req_addr[ch*AW +: AW] = addr;
    bus.flush = (flush_at == 1);
    #1;
    chk({tag, ".grant"}, 64'(bus.req_ready), oh(ch));
    tick();
    bus.req_valid = '0;
    bus.flush = 1'b0;
    if (!exp_hit) begin
      for (int c = 0; c <= stalls; c++) begin
        chk({tag, ".ren"}, 64'(bus.cache_ren), 64'h1);
        chk({tag, ".caddr"}, bus.cache_address, addr);
        chk({tag, ".early_resp"}, 64'(bus.resp_valid), 64'h0);
        chk({tag, ".busy_ready"}, 64'(bus.req_ready), 64'h0);
        bus.cache_miss  = (c < stalls);
        bus.cache_rdata = (c < stalls) ? 64'hDEAD_BEEF_DEAD_BEEF : rdata;
        bus.flush       = (flush_at == 2) && (c == stalls);
        tick();
        bus.cache_miss = 1'b0;
        bus.flush      = 1'b0;
      end
    end
    chk({tag, ".resp_ren"}, 64'(bus.cache_ren), 64'h0);
    chk({tag, ".resp_valid"}, 64'(bus.resp_valid), oh(ch));
    chk({tag, ".resp_data"}, bus.resp_data, exp_data);
    chk({tag, ".resp_ready"}, 64'(bus.req_ready), 64'h0);
    tick();
    chk({tag, ".after"}, 64'(bus.resp_valid), 64'h0);
    chk({tag, ".hold_data"}, bus.resp_data, exp_data);
  endtask

  initial begin
    int rr_exp [4];
    logic [63:0] fa [5];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.flush       = 1'b0;
    bus.cache_rdata = '0;
    bus.cache_miss  = 1'b0;

    // Reset and idle
    tick();
    tick();
    chk_quiet("rst");
    chk("rst.resp_data", bus.resp_data, 64'h0);
    chk("rst.caddr", bus.cache_address, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("idle");
    end

    // Cold miss with three stall cycles, then a hit from the other channel
    xact("cold", 0, ADDR_X, 1'b0, 3, DATA_X, DATA_X, 0);
    xact("hit_ch1", 1, ADDR_X, 1'b1, 0, '0, DATA_X, 0);
    // Low granule bits do not take part in the tag
    xact("hit_lowbits", 0, 64'h0000_0000_8000_100F, 1'b1, 0, '0, DATA_X, 0);

    // Round robin with both channels requesting, last grant ch0
    rr_exp = '{1, 0, 1, 0};
    bus.req_addr  = {ADDR_X, ADDR_X};
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr.grant", 64'(bus.req_ready), oh(rr_exp[i]));
      tick();
      chk("rr.resp_valid", 64'(bus.resp_valid), oh(rr_exp[i]));
      chk("rr.resp_data", bus.resp_data, DATA_X);
      chk("rr.ren", 64'(bus.cache_ren), 64'h0);
      chk("rr.busy_ready", 64'(bus.req_ready), 64'h0);
      tick();
    end
    bus.req_valid = '0;

    // Flush in idle, then the same address misses
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_quiet("flush_idle");
    xact("post_flush", 0, ADDR_X, 1'b0, 0, DATA_X, DATA_X, 0);

    // Flush on the fill cycle: response still delivered, entry left invalid
    xact("flush_fill", 1, ADDR_Y, 1'b0, 1, DATA_Y, DATA_Y, 2);
    xact("flush_fill_re", 1, ADDR_Y, 1'b0, 0, DATA_Y, DATA_Y, 0);

    // FIFO replacement: four fills so far, pointer back at entry 0
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fa[i] = 64'h0000_0000_9000_0000 + 64'(i) * 64'h1000;
      xact("fifo_fill", i % 2, fa[i], 1'b0, 0, 64'h1111_0000_0000_0000 | 64'(i),
           64'h1111_0000_0000_0000 | 64'(i), 0);
    end
    for (int i = 1; i < 5; i++) begin
      xact("fifo_hit", i % 2, fa[i], 1'b1, 0, '0, 64'h1111_0000_0000_0000 | 64'(i), 0);
    end
    xact("fifo_evicted", 0, fa[0], 1'b0, 0, 64'h1111_0000_0000_0000,
         64'h1111_0000_0000_0000, 0);
    // A0 refill landed in entry 1 (pointer was 1), evicting A1
    xact("fifo_ptr", 1, fa[1], 1'b0, 0, 64'h1111_0000_0000_0001,
         64'h1111_0000_0000_0001, 0);
    xact("fifo_keep", 0, fa[3], 1'b1, 0, '0, 64'h1111_0000_0000_0003, 0);

    // Flush in the accept cycle forces a miss on a resident address
    xact("flush_acc", 1, fa[3], 1'b0, 0, 64'h1111_0000_0000_0003,
         64'h1111_0000_0000_0003, 1);

    // Reset while waiting on the cache drops the request
    bus.req_valid = 2'b01;
    bus.req_addr[AW-1:0] = 64'h0000_0000_A000_0000;
    bus.cache_miss = 1'b1;
    tick();
    bus.req_valid = '0;
    chk("rstmid.ren", 64'(bus.cache_ren), 64'h1);
    rst = 1'b1;
    #1;
    chk("rstmid.ren_drop", 64'(bus.cache_ren), 64'h0);
    chk("rstmid.data", bus.resp_data, 64'h0);
    tick();
    rst = 1'b0;
    bus.cache_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("rstmid");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
